fpga_cfg_loader: RTL and testbench
==================================

Name: fpga_cfg_loader

Overview:
Second-generation Altera-style configuration loader. It drives a target FPGA through the nCONFIG/nSTATUS handshake, then streams a bitstream from a DW-bit word source in passive-serial or fast-passive-parallel form. Compared with the first loader it adds:
- parametrised data bus width;
- DCLK divider;
- double-buffered gapless word streaming;
- handshake timeouts and error codes;
- post-CONF_DONE flush clocks;
- abort.

It sits between the bitstream word source (flash/PCIe FIFO) and the target's configuration pins.

Parameters:
DW, 64, input word width; must be a multiple of BUS_W.
BUS_W, 1, data pins per DCLK: 1 (PS), 8 or 16 (FPP).
DIV, 5, clock cycles per DCLK half-period (≥1).
MSEL, 4'b0000, constant driven on msel.
NCFG_LOW, 100, clock cycles n_config is held low (≥1).
STATUS_TO, 100000, timeout in clock cycles for each n_status edge.
FLUSH_CLK, 8, DCLK cycles issued after conf_done rises.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
n_config  out  1  target nCONFIG
n_status  in  1  target nSTATUS
conf_done  in  1  target CONF_DONE
dclk  out  1  configuration clock
data  out  BUS_W  configuration data
n_ce  out  1  target nCE
msel  out  4  mode select, constant MSEL
word  in  DW  bitstream word
word_valid  in  1  word available
word_ready  out  1  word accepted when valid&ready high on the same edge
start  in  1  begin configuration
abort  in  1  cancel configuration
busy  out  1  high outside IDLE/DONE/ERROR
done  out  1  level, high in DONE
error  out  1  level, high in ERROR
err_code  out  3  error cause, held in ERROR

Behaviour:
- Interface: reset is reset, asynchronous, active-high; clock is clock. All outputs are registered.
- Reset values: n_config=1, dclk=0, data=0, n_ce=1, word_ready=0, busy=0, done=0, error=0, err_code=0, state=IDLE, buffers empty.
- Reset mid-operation: return to reset values immediately; any word in flight is lost.
- msel = MSEL always. n_ce = 0 in every state except IDLE.

State machine:
- IDLE: start → NCFG_LOW. n_config=0 from the next cycle.
- NCFG_LOW: hold n_config low for NCFG_LOW cycles. n_status still high at the end → ERROR(1); otherwise → WAIT_STATUS.
- WAIT_STATUS: n_config=1. On n_status high → SHIFT. STATUS_TO cycles elapsed → ERROR(2).
- SHIFT:
  - Holding register: loaded when empty and word_valid, i.e. word_ready = holding empty.
  - Shift register: takes the holding word at each word boundary, giving zero gap when holding is full.
  - Beat k drives word[k*BUS_W +: BUS_W], LSB first. data changes only while dclk is low.
  - dclk rises DIV cycles after data is set, falls DIV cycles later. The beat advances on the fall.
  - After DW/BUS_W beats, the next word is taken. If none is available, dclk stays low (stall; not an error, no timeout).
- SHIFT, conf_done high → FLUSH. Remaining bits are discarded, holding is cleared, word_ready=0.
- FLUSH: issue FLUSH_CLK full dclk cycles with data=0 → DONE.
- n_status low in SHIFT or FLUSH → ERROR(3); checked before conf_done on the same cycle.
- abort in any busy state → ERROR(4). Abort has priority over all other events.
- DONE/ERROR: dclk=0, data=0, word_ready=0. start → NCFG_LOW (restart). start while busy is ignored.
- err_code values: 0 none, 1 nSTATUS never went low, 2 nSTATUS high timeout, 3 nSTATUS low during load (CRC error), 4 aborted. err_code clears to 0 on start.
- Counters sized $clog2(max(STATUS_TO, NCFG_LOW)+1). No wrap: each counter saturates at its limit.

Decomposition:
- Package fpga_cfg_pkg: state enum; err_code typedef enum (ERR_NONE, ERR_NO_STATUS_LOW, ERR_STATUS_TO, ERR_NSTATUS, ERR_ABORT); elaboration check DW % BUS_W == 0.
- Sub-module cfg_dclk_gen: DIV divider with enable, producing dclk plus rise/fall strobes. Disabling it forces dclk low at the next half-period boundary.

Test Plan:
1. DW=64, BUS_W=1, DIV=2, n_status low at NCFG_LOW, high 10 cycles after release; three words streamed back-to-back, conf_done raised after word 3 → 192 dclk rising edges with no gaps, data matches words LSB first, then 8 flush clocks, done=1, err_code=0.
2. BUS_W=16, word=64'h0123_4567_89AB_CDEF → data sequence CDEF, 89AB, 4567, 0123 on four dclk rises.
3. word_valid withheld 50 cycles between words → dclk held low during the gap, no error, correct data resumes afterwards.
4. n_status held high through NCFG_LOW → error=1, err_code=1; n_status never rises, STATUS_TO=100 → err_code=2 after 100 cycles.
5. n_status pulled low mid-SHIFT → ERROR, err_code=3, dclk=0; start again → NCFG_LOW and err_code=0.
6. abort and conf_done asserted on the same cycle in SHIFT → err_code=4, no flush clocks; reset asserted mid-SHIFT → all outputs at reset values immediately.

Source files
------------

// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared types and helpers for the configuration loader.
// Holds the FSM state enum, error-code enum and elaboration helpers.
package fpga_cfg_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_NCFG_LOW,
      S_WAIT_STATUS,
      S_SHIFT,
      S_FLUSH,
      S_DONE,
      S_ERROR
   } state_e;

   typedef enum logic [2:0] {
      ERR_NONE          = 3'd0,
      ERR_NO_STATUS_LOW = 3'd1,
      ERR_STATUS_TO     = 3'd2,
      ERR_NSTATUS       = 3'd3,
      ERR_ABORT         = 3'd4
   } err_e;

   function automatic bit width_ok(int dw, int bw);
      return (bw > 0) && (dw % bw == 0);
   endfunction

   function automatic int max2(int a, int b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic is_busy(state_e s);
      return (s == S_NCFG_LOW) || (s == S_WAIT_STATUS) ||
             (s == S_SHIFT) || (s == S_FLUSH);
   endfunction

endpackage

// File: rtl/fpga_cfg_loader_dclk.sv
// cfg_dclk_gen: DCLK divider, DIV clock cycles per half-period.
// Ports: en_i/clr_i in; dclk_o registered; rise_o/fall_o flag the next edge.
module cfg_dclk_gen #(
   parameter int DIV = 5
) (
   input  logic clock,
   input  logic reset,
   input  logic en_i,
   input  logic clr_i,
   output logic dclk_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          dclk_q, dclk_d;
   logic          at_end;

   assign at_end = (cnt_q == LAST);
   assign dclk_o = dclk_q;
   // Strobes mark the edge on which dclk will toggle, so the
   // caller can update data on that same edge.
   assign rise_o = at_end && !dclk_q && en_i;
   assign fall_o = at_end && dclk_q;

   always_comb begin
      cnt_d  = cnt_q;
      dclk_d = dclk_q;
      if (clr_i || (!dclk_q && !en_i)) begin
         // Idle low; a high phase always runs to its boundary.
         cnt_d  = '0;
         dclk_d = 1'b0;
      end else if (at_end) begin
         cnt_d  = '0;
         dclk_d = !dclk_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         dclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         dclk_q <= dclk_d;
      end
   end

endmodule

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: nCONFIG/nSTATUS handshake, then PS/FPP bitstream streaming.
// Ports: target pins, word source (word/valid/ready), start/abort, status.
module fpga_cfg_loader
   import fpga_cfg_pkg::*;
#(
   parameter int         DW        = 64,
   parameter int         BUS_W     = 1,
   parameter int         DIV       = 5,
   parameter logic [3:0] MSEL      = 4'b0000,
   parameter int         NCFG_LOW  = 100,
   parameter int         STATUS_TO = 100000,
   parameter int         FLUSH_CLK = 8
) (
   input  logic             clock,
   input  logic             reset,
   output logic             n_config,
   input  logic             n_status,
   input  logic             conf_done,
   output logic             dclk,
   output logic [BUS_W-1:0] data,
   output logic             n_ce,
   output logic [3:0]       msel,
   input  logic [DW-1:0]    word,
   input  logic             word_valid,
   output logic             word_ready,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [2:0]       err_code
);

   localparam int NB = DW / BUS_W;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam int CW = $clog2(max2(STATUS_TO, NCFG_LOW) + 1);
   localparam int FW = (FLUSH_CLK > 0) ? $clog2(FLUSH_CLK + 1) : 1;
   localparam logic [CW-1:0] C_MAX   = CW'(max2(STATUS_TO, NCFG_LOW));
   localparam logic [CW-1:0] NL_LAST = CW'(NCFG_LOW - 1);
   localparam logic [CW-1:0] TO_LAST = CW'(STATUS_TO - 1);
   localparam logic [BW-1:0] B_LAST  = BW'(NB - 1);
   localparam logic [FW-1:0] FL_N    = FW'(FLUSH_CLK);

   if (!width_ok(DW, BUS_W)) begin : g_bad_width
      $error("DW must be a multiple of BUS_W");
   end

   state_e           state_q, state_d;
   err_e             err_q, err_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [DW-1:0]    hold_q, hold_d, sh_q, sh_d, sh_nxt;
   logic             hold_vld_q, hold_vld_d;
   logic             sh_vld_q, sh_vld_d;
   logic [BW-1:0]    beat_q, beat_d;
   logic [FW-1:0]    fl_q, fl_d;
   logic [BUS_W-1:0] data_q, data_d;
   logic             n_config_q, n_ce_q, word_ready_q;
   logic             busy_q, done_q, error_q;
   logic             en, clr, rise, fall, dclk_w;

   cfg_dclk_gen #(.DIV(DIV)) u_dclk (
      .clock  (clock),
      .reset  (reset),
      .en_i   (en),
      .clr_i  (clr),
      .dclk_o (dclk_w),
      .rise_o (rise),
      .fall_o (fall)
   );

   assign en = ((state_q == S_SHIFT) && sh_vld_q) ||
               (state_q == S_FLUSH);
   assign clr = (state_d == S_DONE) || (state_d == S_ERROR);
   assign sh_nxt = sh_q >> BUS_W;

   assign n_config   = n_config_q;
   assign dclk       = dclk_w;
   assign data       = data_q;
   assign n_ce       = n_ce_q;
   assign msel       = MSEL;
   assign word_ready = word_ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign err_code   = err_q;

   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      cnt_d      = (cnt_q == C_MAX) ? cnt_q : cnt_q + 1'b1;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      sh_d       = sh_q;
      sh_vld_d   = sh_vld_q;
      beat_d     = beat_q;
      fl_d       = fl_q;
      data_d     = data_q;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d = S_NCFG_LOW;
               err_d   = ERR_NONE;
               cnt_d   = '0;
            end
         end
         S_NCFG_LOW: begin
            if (cnt_q == NL_LAST) begin
               cnt_d = '0;
               if (n_status) begin
                  state_d = S_ERROR;
                  err_d   = ERR_NO_STATUS_LOW;
               end else begin
                  state_d = S_WAIT_STATUS;
               end
            end
         end
         S_WAIT_STATUS: begin
            if (n_status) begin
               state_d = S_SHIFT;
            end else if (cnt_q == TO_LAST) begin
               state_d = S_ERROR;
               err_d   = ERR_STATUS_TO;
            end
         end
         S_SHIFT: begin
            if (!n_status) begin
               state_d = S_ERROR;
               err_d   = ERR_NSTATUS;
            end else if (conf_done) begin
               state_d    = S_FLUSH;
               hold_vld_d = 1'b0;
               sh_vld_d   = 1'b0;
               fl_d       = '0;
               if (!dclk_w) data_d = '0;
            end else begin
               if (word_ready_q && word_valid) begin
                  hold_d     = word;
                  hold_vld_d = 1'b1;
               end
               // Reload on the last fall when a word is waiting,
               // so consecutive words stream without a gap.
               if ((!sh_vld_q || (fall && beat_q == B_LAST)) &&
                   hold_vld_q) begin
                  sh_d       = hold_q;
                  data_d     = hold_q[BUS_W-1:0];
                  beat_d     = '0;
                  sh_vld_d   = 1'b1;
                  hold_vld_d = 1'b0;
               end else if (sh_vld_q && fall) begin
                  if (beat_q == B_LAST) begin
                     sh_vld_d = 1'b0;
                  end else begin
                     sh_d   = sh_nxt;
                     data_d = sh_nxt[BUS_W-1:0];
                     beat_d = beat_q + 1'b1;
                  end
               end
            end
         end
         S_FLUSH: begin
            if (!n_status) begin
               state_d = S_ERROR;
               err_d   = ERR_NSTATUS;
            end else begin
               if (!dclk_w || fall) data_d = '0;
               if (rise && fl_q != FL_N) fl_d = fl_q + 1'b1;
               if (fl_q == FL_N && (fall || !dclk_w)) state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (abort && busy_q) begin
         state_d = S_ERROR;
         err_d   = ERR_ABORT;
      end
      if ((state_d == S_DONE) || (state_d == S_ERROR)) begin
         hold_vld_d = 1'b0;
         sh_vld_d   = 1'b0;
         data_d     = '0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         err_q        <= ERR_NONE;
         cnt_q        <= '0;
         hold_q       <= '0;
         hold_vld_q   <= 1'b0;
         sh_q         <= '0;
         sh_vld_q     <= 1'b0;
         beat_q       <= '0;
         fl_q         <= '0;
         data_q       <= '0;
         n_config_q   <= 1'b1;
         n_ce_q       <= 1'b1;
         word_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
         hold_q       <= hold_d;
         hold_vld_q   <= hold_vld_d;
         sh_q         <= sh_d;
         sh_vld_q     <= sh_vld_d;
         beat_q       <= beat_d;
         fl_q         <= fl_d;
         data_q       <= data_d;
         n_config_q   <= (state_d != S_NCFG_LOW);
         n_ce_q       <= (state_d == S_IDLE);
         word_ready_q <= (state_d == S_SHIFT) && !hold_vld_d;
         busy_q       <= is_busy(state_d);
         done_q       <= (state_d == S_DONE);
         error_q      <= (state_d == S_ERROR);
      end
   end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb_fpga_cfg_loader: directed bench for fpga_cfg_loader.
// u0 runs passive-serial (BUS_W=1), u1 runs 16-bit fast-passive-parallel.
module tb_fpga_cfg_loader;

   localparam int DIV = 2;
   localparam int PER = 2 * DIV;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic        n_config, n_status, conf_done, dclk, n_ce;
   logic        word_valid, word_ready, start, abort;
   logic        busy, done, error;
   logic [0:0]  data;
   logic [3:0]  msel;
   logic [63:0] word;
   logic [2:0]  err_code;

   logic        b_n_config, b_n_status, b_conf_done, b_dclk, b_n_ce;
   logic        b_word_valid, b_word_ready, b_start, b_abort;
   logic        b_busy, b_done, b_error;
   logic [15:0] b_data;
   logic [3:0]  b_msel;
   logic [63:0] b_word;
   logic [2:0]  b_err_code;

   fpga_cfg_loader #(
      .DW(64), .BUS_W(1), .DIV(DIV), .MSEL(4'b1010),
      .NCFG_LOW(10), .STATUS_TO(100), .FLUSH_CLK(8)
   ) u0 (
      .clock(clock), .reset(reset), .n_config(n_config),
      .n_status(n_status), .conf_done(conf_done), .dclk(dclk),
      .data(data), .n_ce(n_ce), .msel(msel), .word(word),
      .word_valid(word_valid), .word_ready(word_ready),
      .start(start), .abort(abort), .busy(busy), .done(done),
      .error(error), .err_code(err_code)
   );

   fpga_cfg_loader #(
      .DW(64), .BUS_W(16), .DIV(DIV), .MSEL(4'b0000),
      .NCFG_LOW(10), .STATUS_TO(100), .FLUSH_CLK(8)
   ) u1 (
      .clock(clock), .reset(reset), .n_config(b_n_config),
      .n_status(b_n_status), .conf_done(b_conf_done), .dclk(b_dclk),
      .data(b_data), .n_ce(b_n_ce), .msel(b_msel), .word(b_word),
      .word_valid(b_word_valid), .word_ready(b_word_ready),
      .start(b_start), .abort(b_abort), .busy(b_busy), .done(b_done),
      .error(b_error), .err_code(b_err_code)
   );

   typedef struct packed {
      logic [63:0]      w;
      logic [3:0][15:0] beats;
   } fpp_vec_t;

   fpp_vec_t    fv [2];
   logic [63:0] tv [3];

   int checks = 0;
   int errors = 0;

   // Rising-edge capture, sampled on the falling system-clock edge.
   int         cyc = 0;
   int         rises = 0;
   int         glitch = 0;
   logic       dclk_p = 1'b0;
   logic [0:0] data_p = 1'b0;
   logic       rdat [$];
   int         rtim [$];

   int          b_rises = 0;
   logic        b_dclk_p = 1'b0;
   logic [15:0] b_rdat [$];

   always @(negedge clock) begin
      cyc++;
      if (dclk && !dclk_p) begin
         rdat.push_back(data[0]);
         rtim.push_back(cyc);
         rises++;
      end
      if (dclk && dclk_p && data !== data_p) glitch++;
      dclk_p = dclk;
      data_p = data;
      if (b_dclk && !b_dclk_p) begin
         b_rdat.push_back(b_data);
         b_rises++;
      end
      b_dclk_p = b_dclk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end, want finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_rst(input string nm);
      chk(nm, {n_config, dclk, data, n_ce, word_ready,
               busy, done, error, err_code},
          {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
   endtask

   task automatic clr_mon();
      rdat.delete();
      rtim.delete();
      rises = 0;
      glitch = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   // Target model: nSTATUS follows nCONFIG low, released 10 cycles late.
   task automatic hs(output int lowc);
      int n;
      pulse_start();
      n = 0;
      while (n_config !== 1'b0 && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk("hs_ncfg_fall", n_config, 1'b0);
      n_status = 1'b0;
      lowc = 0;
      while (n_config !== 1'b1 && lowc < 1000) begin
         @(negedge clock);
         lowc++;
      end
      repeat (10) @(negedge clock);
      n_status = 1'b1;
   endtask

   task automatic send(input string nm, input logic [63:0] w);
      int n;
      word = w;
      word_valid = 1'b1;
      n = 0;
      while (!word_ready && n < 2000) begin
         @(negedge clock);
         n++;
      end
      chk(nm, word_ready, 1'b1);
      @(negedge clock);
      word_valid = 1'b0;
   endtask

   task automatic b_send(input string nm, input logic [63:0] w);
      int n;
      b_word = w;
      b_word_valid = 1'b1;
      n = 0;
      while (!b_word_ready && n < 2000) begin
         @(negedge clock);
         n++;
      end
      chk(nm, b_word_ready, 1'b1);
      @(negedge clock);
      b_word_valid = 1'b0;
   endtask

   task automatic wait_rises(input string nm, input int cnt);
      int n;
      n = 0;
      while (!(rises >= cnt && !dclk) && n < 3000) begin
         @(negedge clock);
         n++;
      end
      chk(nm, rises >= cnt, 1'b1);
   endtask

   initial begin
      int          n, lowc, bad, hi, r;
      logic [63:0] wa, wb, wc;

      tv[0] = 64'hDEAD_BEEF_0123_4567;
      tv[1] = 64'hA5A5_5A5A_FFFF_0000;
      tv[2] = 64'h8000_0000_0000_0001;
      fv[0] = '{w: 64'h0123_4567_89AB_CDEF,
                beats: {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF}};
      fv[1] = '{w: 64'hFEDC_BA98_7654_3210,
                beats: {16'hFEDC, 16'hBA98, 16'h7654, 16'h3210}};
      wa = 64'hF0F0_1234_5678_9ABC;
      wb = 64'h0F0F_CAFE_BABE_0001;
      wc = 64'h1357_9BDF_2468_ACE0;

      n_status = 1'b1;   conf_done = 1'b0;  word = '0;
      word_valid = 1'b0; start = 1'b0;      abort = 1'b0;
      b_n_status = 1'b1; b_conf_done = 1'b0; b_word = '0;
      b_word_valid = 1'b0; b_start = 1'b0;  b_abort = 1'b0;

      repeat (3) @(negedge clock);
      chk_rst("reset_vals");
      chk("msel_u0", msel, 4'b1010);
      reset = 1'b0;
      @(negedge clock);
      chk_rst("idle_vals");
      chk("msel_u1", b_msel, 4'h0);
      chk("u1_idle_nce", {b_n_ce, b_busy, b_dclk}, 3'b100);

      // FPP 16-bit: beats leave the word low half-word first.
      b_start = 1'b1;
      @(negedge clock);
      b_start = 1'b0;
      b_n_status = 1'b0;
      n = 0;
      while (b_n_config !== 1'b1 && n < 100) begin
         @(negedge clock);
         n++;
      end
      repeat (10) @(negedge clock);
      b_n_status = 1'b1;
      for (int i = 0; i < 2; i++) b_send("fpp_send", fv[i].w);
      n = 0;
      while (!(b_rises >= 8 && !b_dclk) && n < 500) begin
         @(negedge clock);
         n++;
      end
      chk("fpp_rises", b_rises, 8);
      b_conf_done = 1'b1;
      n = 0;
      while (!b_done && n < 200) begin
         @(negedge clock);
         n++;
      end
      b_conf_done = 1'b0;
      chk("fpp_done", {b_done, b_error, b_err_code}, 5'b10000);
      chk("fpp_total_rises", b_rises, 16);
      if (b_rdat.size() >= 16) begin
         for (int i = 0; i < 8; i++)
            chk("fpp_beat", b_rdat[i], fv[i/4].beats[i%4]);
         bad = 0;
         for (int i = 8; i < 16; i++) if (b_rdat[i] !== 16'h0) bad++;
         chk("fpp_flush_zero", bad, 0);
      end

      // PS: three back-to-back words, then conf_done and flush.
      clr_mon();
      hs(lowc);
      chk("ncfg_low_len", lowc, 10);
      chk("busy_nce", {busy, n_ce}, 2'b10);
      for (int i = 0; i < 3; i++) send("ps_send", tv[i]);
      wait_rises("ps_192", 192);
      repeat (3) @(negedge clock);
      chk("ps_rises", rises, 192);
      conf_done = 1'b1;
      n = 0;
      while (!done && n < 200) begin
         @(negedge clock);
         n++;
      end
      conf_done = 1'b0;
      chk("ps_done", {done, error, busy, err_code}, 6'b100000);
      chk("ps_done_pins", {dclk, data, word_ready}, 3'b000);
      chk("ps_total_rises", rises, 200);
      if (rdat.size() >= 200) begin
         bad = 0;
         for (int i = 0; i < 192; i++) begin
            wa = tv[i/64];
            if (rdat[i] !== wa[i%64]) bad++;
         end
         chk("ps_bits", bad, 0);
         bad = 0;
         for (int i = 192; i < 200; i++) if (rdat[i] !== 1'b0) bad++;
         chk("ps_flush_zero", bad, 0);
         bad = 0;
         for (int i = 1; i < 200; i++)
            if (i != 192 && rtim[i] - rtim[i-1] != PER) bad++;
         chk("ps_no_gaps", bad, 0);
      end
      chk("ps_data_stable_high", glitch, 0);

      // Source stall of 50 cycles, then abort together with conf_done.
      wa = 64'hF0F0_1234_5678_9ABC;
      clr_mon();
      hs(lowc);
      send("stall_send_a", wa);
      wait_rises("stall_a_done", 64);
      hi = 0;
      repeat (50) begin
         @(negedge clock);
         if (dclk) hi++;
      end
      chk("stall_dclk_low", hi, 0);
      chk("stall_state", {error, busy, word_ready}, 3'b011);
      send("stall_send_b", wb);
      wait_rises("stall_b_run", 80);
      abort = 1'b1;
      conf_done = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      conf_done = 1'b0;
      chk("abort_err", {error, done, busy, err_code}, 6'b100100);
      chk("abort_pins", {dclk, data, word_ready}, 3'b000);
      r = rises;
      repeat (20) @(negedge clock);
      chk("abort_no_flush", rises, r);
      if (rdat.size() >= 80) begin
         bad = 0;
         for (int i = 0; i < 80; i++)
            if (rdat[i] !== ((i < 64) ? wa[i] : wb[i-64])) bad++;
         chk("stall_bits", bad, 0);
         chk("stall_gap", (rtim[64] - rtim[63]) >= 50, 1'b1);
      end

      // nSTATUS never goes low while nCONFIG is held low.
      n_status = 1'b1;
      pulse_start();
      chk("start_clears_err", err_code, 3'd0);
      chk("restart_pins", {n_config, busy, error}, 3'b010);
      n = 0;
      while (!error && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk("err1_time", n, 10);
      chk("err1_code", err_code, 3'd1);

      // nSTATUS stays low: timeout STATUS_TO cycles after release.
      n_status = 1'b0;
      pulse_start();
      n = 0;
      while (n_config !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      n = 0;
      while (!error && n < 300) begin
         @(negedge clock);
         n++;
      end
      chk("err2_time", n, 100);
      chk("err2_code", err_code, 3'd2);

      // nSTATUS low during load.
      n_status = 1'b1;
      clr_mon();
      hs(lowc);
      send("crc_send", wc);
      wait_rises("crc_run", 20);
      n_status = 1'b0;
      @(negedge clock);
      chk("err3", {error, busy, err_code}, 5'b10011);
      chk("err3_dclk", dclk, 1'b0);
      pulse_start();
      chk("err3_restart", {n_config, error, busy, err_code}, 6'b001000);

      // Asynchronous reset in the middle of SHIFT.
      n = 0;
      while (n_config !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      n_status = 1'b1;
      clr_mon();
      send("rst_send", wc);
      wait_rises("rst_run", 5);
      n = 0;
      while (!dclk && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk("rst_pre_dclk", dclk, 1'b1);
      #2 reset = 1'b1;
      #1 chk_rst("async_reset");
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk_rst("post_reset");

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
